// File: rtl/fp_add_sub32.sv
// fp_add_sub32 - IEEE-754 binary32 adder, two-stage pipeline.
// Out = A + B. Subtraction is done by the caller flipping B[31].
// Denormal inputs are flushed to signed zero. Rounding is to nearest, ties to even.
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   in_valid  A/B carry an operand pair this cycle
//   A, B      binary32 operands
//   out_valid Out/isZero hold the result of the pair accepted 2 cycles earlier
//   Out       registered binary32 sum
//   isZero    Out is +0 or -0
module fp_add_sub32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        out_valid,
    output logic [31:0] Out,
    output logic        isZero
);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // ---------------- stage 1: classify, swap, align ----------------
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [30:0] mag_a, mag_b;
    logic        a_ge;
    logic        spec_d;
    logic [31:0] spec_val_d;
    logic        sign_d, sub_d;
    logic [7:0]  exp_d, y_exp, shamt;
    logic [23:0] mx_d, my_full;
    logic [26:0] my_d;
    logic [49:0] sh;

    always_comb begin
        a_zero = (A[30:23] == 8'h00);
        b_zero = (B[30:23] == 8'h00);
        a_inf  = (A[30:23] == 8'hFF) && (A[22:0] == 23'd0);
        b_inf  = (B[30:23] == 8'hFF) && (B[22:0] == 23'd0);
        a_nan  = (A[30:23] == 8'hFF) && (A[22:0] != 23'd0);
        b_nan  = (B[30:23] == 8'hFF) && (B[22:0] != 23'd0);
        mag_a  = a_zero ? 31'd0 : A[30:0];
        mag_b  = b_zero ? 31'd0 : B[30:0];
        a_ge   = (mag_a >= mag_b);

        spec_d     = 1'b1;
        spec_val_d = QNAN;
        if (a_nan || b_nan)
            spec_val_d = QNAN;
        else if (a_inf && b_inf && (A[31] != B[31]))
            spec_val_d = QNAN;
        else if (a_inf)
            spec_val_d = A;
        else if (b_inf)
            spec_val_d = B;
        else if (a_zero && b_zero)
            spec_val_d = {A[31] & B[31], 31'd0};  // -0 only when both are -0
        else
            spec_d = 1'b0;

        sign_d  = a_ge ? A[31] : B[31];
        sub_d   = A[31] ^ B[31];
        exp_d   = a_ge ? A[30:23] : B[30:23];
        y_exp   = a_ge ? B[30:23] : A[30:23];
        mx_d    = a_ge ? {1'b1, A[22:0]} : {1'b1, B[22:0]};
        my_full = a_ge ? (b_zero ? 24'd0 : {1'b1, B[22:0]})
                       : (a_zero ? 24'd0 : {1'b1, A[22:0]});
        shamt   = exp_d - y_exp;

        // 24 significand bits + guard + round + sticky; a large shift leaves sticky only
        sh = '0;
        if (shamt >= 8'd26) begin
            my_d = {26'd0, |my_full};
        end else begin
            sh   = {my_full, 26'd0} >> shamt;
            my_d = {sh[49:24], |sh[23:0]};
        end
    end

    logic        v1_q, spec_q, sign_q, sub_q;
    logic [31:0] spec_val_q;
    logic [7:0]  exp_q;
    logic [23:0] mx_q;
    logic [26:0] my_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q       <= 1'b0;
            spec_q     <= 1'b0;
            spec_val_q <= 32'd0;
            sign_q     <= 1'b0;
            sub_q      <= 1'b0;
            exp_q      <= 8'd0;
            mx_q       <= 24'd0;
            my_q       <= 27'd0;
        end else begin
            v1_q <= in_valid;
            if (in_valid) begin
                spec_q     <= spec_d;
                spec_val_q <= spec_val_d;
                sign_q     <= sign_d;
                sub_q      <= sub_d;
                exp_q      <= exp_d;
                mx_q       <= mx_d;
                my_q       <= my_d;
            end
        end
    end

    // ---------------- stage 2: add, normalise, round ----------------
    logic [27:0]       sum;
    logic [26:0]       norm;
    logic [4:0]        lz;
    logic              found;
    logic signed [9:0] e_norm, e_fin;
    logic              round_up;
    logic [24:0]       mant_r;
    logic [22:0]       frac_fin;
    logic [31:0]       res_d;

    always_comb begin
        // |X| >= |Y| so the difference never goes negative
        sum = sub_q ? ({1'b0, mx_q, 3'b000} - {1'b0, my_q})
                    : ({1'b0, mx_q, 3'b000} + {1'b0, my_q});

        lz    = 5'd0;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found && sum[i]) begin
                lz    = 5'(26 - i);
                found = 1'b1;
            end
        end

        if (sum[27]) begin
            norm   = {sum[27:2], sum[1] | sum[0]};
            e_norm = $signed({2'b00, exp_q}) + 10'sd1;
        end else begin
            norm   = sum[26:0] << lz;
            e_norm = $signed({2'b00, exp_q}) - $signed({5'd0, lz});
        end

        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        mant_r   = {1'b0, norm[26:3]} + {24'd0, round_up};
        if (mant_r[24]) begin
            e_fin    = e_norm + 10'sd1;
            frac_fin = mant_r[23:1];
        end else begin
            e_fin    = e_norm;
            frac_fin = mant_r[22:0];
        end

        if (spec_q)
            res_d = spec_val_q;
        else if (sum == 28'd0)
            res_d = 32'h0000_0000;              // exact cancellation
        else if (e_fin < 10'sd1)
            res_d = {sign_q, 31'd0};            // underflow flushes to signed zero
        else if (e_fin >= 10'sd255)
            res_d = {sign_q, 8'hFF, 23'd0};
        else
            res_d = {sign_q, e_fin[7:0], frac_fin};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            Out       <= 32'd0;
            isZero    <= 1'b1;
        end else begin
            out_valid <= v1_q;
            if (v1_q) begin
                Out    <= res_d;
                isZero <= (res_d[30:0] == 31'd0);
            end
        end
    end
endmodule

// File: tb/tb_fp_add_sub32.sv
module tb_fp_add_sub32;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] A = 32'd0, B = 32'd0;
    logic        out_valid;
    logic [31:0] Out;
    logic        isZero;
    int          checks = 0;
    int          failures = 0;

    fp_add_sub32 dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(A), .B(B),
        .out_valid(out_valid), .Out(Out), .isZero(isZero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run1(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input logic expz);
        A = a; B = b; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; A = 32'd0; B = 32'd0;
        check({tag, "_vld1"}, {31'd0, out_valid}, 32'd0);
        tick();
        check({tag, "_vld2"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_out"}, Out, exp);
        check({tag, "_zero"}, {31'd0, isZero}, {31'd0, expz});
    endtask

    logic [31:0] bb_a [4] = '{32'h40C80000, 32'h40C80000, 32'h40C80000, 32'hC0580000};
    logic [31:0] bb_b [4] = '{32'h40C80000, 32'hC0C80000, 32'hC0F80000, 32'h40C80000};
    logic [31:0] bb_e [4] = '{32'h41480000, 32'h00000000, 32'hBFC00000, 32'h40380000};

    initial begin
        #12;
        check("rst_out", Out, 32'h0);
        check("rst_zero", {31'd0, isZero}, 32'd1);
        check("rst_vld", {31'd0, out_valid}, 32'd0);
        rst_n = 1'b1;
        tick();

        run1("add_6p25", 32'h40C80000, 32'h40C80000, 32'h41480000, 1'b0);
        run1("cancel",   32'h40C80000, 32'hC0C80000, 32'h00000000, 1'b1);
        run1("sub_neg",  32'h40C80000, 32'hC0F80000, 32'hBFC00000, 1'b0);
        run1("sub_pos",  32'hC0580000, 32'h40C80000, 32'h40380000, 1'b0);
        run1("inf_nan",  32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0);
        run1("ovf",      32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b0);
        run1("tie_even", 32'h3F800000, 32'h33800000, 32'h3F800000, 1'b0);
        run1("tie_up",   32'h3F800001, 32'h33800000, 32'h3F800002, 1'b0);
        run1("nan_in",   32'h7F800001, 32'h3F800000, 32'h7FC00000, 1'b0);
        run1("inf_fin",  32'hFF800000, 32'h3F800000, 32'hFF800000, 1'b0);
        run1("inf_inf",  32'h7F800000, 32'h7F800000, 32'h7F800000, 1'b0);
        run1("pz_nz",    32'h00000000, 32'h80000000, 32'h00000000, 1'b1);
        run1("nz_nz",    32'h80000000, 32'h80000000, 32'h80000000, 1'b1);
        run1("zero_x",   32'h00000000, 32'hC0580000, 32'hC0580000, 1'b0);
        run1("denorm",   32'h00000001, 32'h3F800000, 32'h3F800000, 1'b0);
        run1("uflow",    32'h00800000, 32'h80C00000, 32'h80000000, 1'b1);
        run1("far_shift",32'h4B800000, 32'h3F800000, 32'h4B800000, 1'b0);

        // hold: Out does not change while out_valid is low
        tick();
        check("hold_vld", {31'd0, out_valid}, 32'd0);
        check("hold_out", Out, 32'h4B800000);

        // back-to-back
        for (int t = 0; t < 6; t++) begin
            if (t < 4) begin
                A = bb_a[t]; B = bb_b[t]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0; A = 32'd0; B = 32'd0;
            end
            tick();
            if (t >= 1 && t <= 4) begin
                check($sformatf("b2b_vld%0d", t - 1), {31'd0, out_valid}, 32'd1);
                check($sformatf("b2b_out%0d", t - 1), Out, bb_e[t - 1]);
            end
        end

        // reset while a pair is in flight
        run1("pre_rst", 32'h40C80000, 32'h40C80000, 32'h41480000, 1'b0);
        A = 32'h40C80000; B = 32'hC0F80000; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("arst_out", Out, 32'h0);
        check("arst_zero", {31'd0, isZero}, 32'd1);
        check("arst_vld", {31'd0, out_valid}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_vld", {31'd0, out_valid}, 32'd0);
        check("post_rst_out", Out, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
